// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states and port owner.
// No logic, types and constants only.
// Imported by mem_port_arbiter and its streak counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Wide enough for STREAK_MAX up to 15.
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starvation_counter.sv
// Saturating count of data grants given while fetch was waiting.
// Count updates one cycle after i_inc/i_clr; o_at_max is a combinational decode of the count.
// No backpressure: clear wins over increment, increment holds at MAX.
module mem_port_arbiter_starvation_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = STREAK_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_count;

  // Streak register: clear has priority, increment saturates at MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != L_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_max = (r_count == L_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read) and load/store, one transaction at a time.
// mem_req rises the cycle after a request is seen in IDLE; gnt on mem_ready, rvalid/done on mem_rvalid.
// mem_* held stable until mem_ready; requesters hold req until gnt; fetch forced in after STREAK_MAX data wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  i_flush,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  owner_t              r_owner;
  logic                r_drop;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;

  logic                w_at_max;
  logic                w_fetch_wins;
  logic                w_arb;
  logic                w_hs;
  logic                w_fetch_busy;
  logic                w_fetch_resp;
  logic                w_streak_inc;
  logic                w_streak_clr;
  logic                w_i_gnt;
  logic                w_d_gnt;
  logic                w_i_rvalid;
  logic                w_d_done;

  // Data normally wins; fetch wins when alone or when its wait streak is exhausted.
  assign w_fetch_wins = i_req & (~d_req | w_at_max);
  assign w_arb        = (r_state == IDLE) & (i_req | d_req);
  assign w_hs         = (r_state == ISSUE) & mem_ready;
  assign w_fetch_busy = (r_owner == OWN_FETCH) & ((r_state == ISSUE) | (r_state == WAIT_RD));
  assign w_fetch_resp = (r_state == WAIT_RD) & mem_rvalid & (r_owner == OWN_FETCH);

  // Streak counts data grants that overtook a waiting fetch.
  assign w_streak_inc = w_hs & (r_owner == OWN_DATA) & i_req;
  assign w_streak_clr = (w_hs & (r_owner == OWN_FETCH)) | ((r_state == IDLE) & ~i_req);

  mem_port_arbiter_starvation_counter #(
    .MAX (STREAK_MAX),
    .W   (STREAK_W)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_streak_clr),
    .i_inc    (w_streak_inc),
    .o_at_max (w_at_max)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake pulses; a store completes on its own accept cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_i_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_i_rvalid  = 1'b0;
    w_d_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (r_owner == OWN_FETCH) begin
            w_i_gnt     = 1'b1;
            w_state_nxt = WAIT_RD;
          end else begin
            w_d_gnt = 1'b1;
            if (r_mem_we) begin
              w_d_done    = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WAIT_RD;
            end
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          if (r_owner == OWN_FETCH) begin
            // A flush arriving with the response still kills it.
            w_i_rvalid = ~(r_drop | i_flush);
          end else begin
            w_d_done = 1'b1;
          end
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request registers: capture the winner in IDLE, hold until accepted; track flushed fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_owner     <= OWN_FETCH;
      r_drop      <= 1'b0;
    end else begin
      if (w_arb) begin
        r_mem_req <= 1'b1;
        if (w_fetch_wins) begin
          r_owner     <= OWN_FETCH;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= i_addr;
          r_mem_wdata <= '0;
          r_mem_wstrb <= '0;
        end else begin
          r_owner     <= OWN_DATA;
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
          r_mem_wstrb <= d_wstrb;
        end
      end else if (w_hs) begin
        r_mem_req <= 1'b0;
      end

      if (w_fetch_resp) begin
        r_drop <= 1'b0;
      end else if (i_flush && w_fetch_busy) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Handshake pulses are forced low while reset is held, whatever the state.
  assign i_gnt     = w_i_gnt & ~rst;
  assign d_gnt     = w_d_gnt & ~rst;
  assign i_rvalid  = w_i_rvalid & ~rst;
  assign d_done    = w_d_done & ~rst;

  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
